// File: rtl/sram_writer.sv
// Write-side controller for the external 1M x 16 asynchronous SRAM. Takes a burst
// command plus a valid/ready word stream and writes each word with a WE_n-controlled cycle.
module sram_writer #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 20,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_written,
    output logic              CE_n,
    output logic              OE_n,
    output logic              WE_n,
    output logic              UB_n,
    output logic              LB_n,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] IO
);

    localparam int PH_W = 8;
    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_PULSE  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [PH_W-1:0]   ph_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [CNT_W-1:0]  words_r;
    logic              io_oe_r;
    logic              ce_n_r;
    logic              oe_n_r;
    logic              we_n_r;
    logic              ub_n_r;
    logic              lb_n_r;
    logic              din_ready_r;
    logic              busy_r;
    logic              done_r;

    logic              start_ok_s;
    logic              accept_s;
    logic              hold_last_s;
    logic              active_s;
    logic              in_burst_s;

    assign start_ok_s  = (state_r == S_IDLE) && start && (word_count != {CNT_W{1'b0}});
    assign accept_s    = (state_r == S_WAIT) && din_valid;
    assign hold_last_s = (state_r == S_HOLD) && (ph_cnt_r == HOLD_LAST);
    // Output registers are loaded from the next state so they line up with it.
    assign active_s    = (state_nxt_s == S_SETUP) || (state_nxt_s == S_PULSE) ||
                         (state_nxt_s == S_HOLD);
    assign in_burst_s  = active_s || (state_nxt_s == S_WAIT);

    // Next-state decode for the write-cycle sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (word_count != {CNT_W{1'b0}}) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_FINISH;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (din_valid) begin
                    state_nxt_s = S_SETUP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_SETUP: begin
                if (ph_cnt_r == SETUP_LAST) begin
                    state_nxt_s = S_PULSE;
                end else begin
                    state_nxt_s = S_SETUP;
                end
            end
            S_PULSE: begin
                if (ph_cnt_r == PULSE_LAST) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_PULSE;
                end
            end
            S_HOLD: begin
                if (ph_cnt_r == HOLD_LAST) begin
                    if (remaining_r == CNT_W'(1'b1)) begin
                        state_nxt_s = S_FINISH;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_FINISH: state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // State, phase counter and registered SRAM/handshake controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ph_cnt_r    <= {PH_W{1'b0}};
            io_oe_r     <= 1'b0;
            ce_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            we_n_r      <= 1'b1;
            ub_n_r      <= 1'b1;
            lb_n_r      <= 1'b1;
            din_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ph_cnt_r    <= (state_nxt_s == state_r) ? ph_cnt_r + PH_W'(1'b1) : {PH_W{1'b0}};
            io_oe_r     <= active_s;
            ce_n_r      <= ~active_s;
            oe_n_r      <= 1'b1;
            we_n_r      <= (state_nxt_s != S_PULSE);
            ub_n_r      <= ~active_s;
            lb_n_r      <= ~active_s;
            din_ready_r <= (state_nxt_s == S_WAIT);
            busy_r      <= in_burst_s;
            done_r      <= (state_nxt_s == S_FINISH);
        end
    end

    // Burst datapath: address only moves at the end of HOLD, data only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= {ADDR_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            words_r     <= {CNT_W{1'b0}};
        end else begin
            if (start_ok_s) begin
                addr_r      <= base_addr;
                remaining_r <= word_count;
                words_r     <= {CNT_W{1'b0}};
            end else if (hold_last_s) begin
                addr_r      <= addr_r + ADDR_W'(1'b1);
                remaining_r <= remaining_r - CNT_W'(1'b1);
                words_r     <= words_r + CNT_W'(1'b1);
            end
            if (accept_s) begin
                data_r <= din;
            end
        end
    end

    assign din_ready     = din_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = words_r;
    assign CE_n          = ce_n_r;
    assign OE_n          = oe_n_r;
    assign WE_n          = we_n_r;
    assign UB_n          = ub_n_r;
    assign LB_n          = lb_n_r;
    assign addr          = addr_r;
    assign IO            = io_oe_r ? data_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_writer.sv
// Bench for sram_writer: two instances (default timing and 2/3/2 timing), per-cycle
// bus traces analysed against write order, cycle timing and bus-stability rules.
module tb_sram_writer;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int CW = 20;

    logic          clk;
    logic          rst;
    logic          start_v     [2];
    logic [AW-1:0] base_v      [2];
    logic [CW-1:0] cnt_v       [2];
    logic [DW-1:0] din_v       [2];
    logic          din_valid_v [2];
    logic          rdy_v       [2];
    logic          busy_v      [2];
    logic          done_v      [2];
    logic [CW-1:0] ww_v        [2];
    logic          ce_v        [2];
    logic          oe_v        [2];
    logic          we_v        [2];
    logic          ub_v        [2];
    logic          lb_v        [2];
    logic [AW-1:0] addr_v      [2];
    tri1  [DW-1:0] io0;
    tri1  [DW-1:0] io1;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic          we_n, ce_n, oe_n, ub_n, lb_n, busy, done, rdy;
        logic [AW-1:0] addr;
        logic [DW-1:0] io;
        logic [CW-1:0] ww;
    } samp_t;

    samp_t         tr[$];
    logic [DW-1:0] wdata[$];

    sram_writer u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_v[0]), .word_count(cnt_v[0]),
        .din(din_v[0]), .din_valid(din_valid_v[0]), .din_ready(rdy_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .words_written(ww_v[0]), .CE_n(ce_v[0]), .OE_n(oe_v[0]), .WE_n(we_v[0]),
        .UB_n(ub_v[0]), .LB_n(lb_v[0]), .addr(addr_v[0]), .IO(io0)
    );

    sram_writer #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_v[1]), .word_count(cnt_v[1]),
        .din(din_v[1]), .din_valid(din_valid_v[1]), .din_ready(rdy_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .words_written(ww_v[1]), .CE_n(ce_v[1]), .OE_n(oe_v[1]), .WE_n(we_v[1]),
        .UB_n(ub_v[1]), .LB_n(lb_v[1]), .addr(addr_v[1]), .IO(io1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic samp_t sample(input int d);
        samp_t s;
        s.we_n = we_v[d];  s.ce_n = ce_v[d];  s.oe_n = oe_v[d];
        s.ub_n = ub_v[d];  s.lb_n = lb_v[d];  s.busy = busy_v[d];
        s.done = done_v[d]; s.rdy = rdy_v[d]; s.addr = addr_v[d];
        s.io   = (d == 0) ? io0 : io1;
        s.ww   = ww_v[d];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        wdata.delete();
        for (int i = 0; i < n; i++) wdata.push_back(DW'($urandom_range(0, 32'hFFFE)));
    endtask

    // Issue one command and record the bus every cycle until two cycles past done.
    task automatic run_burst(input int d, input logic [AW-1:0] base, input int n,
                             input int stall_word, input int stall_len,
                             input bit rand_valid, input int restart_at);
        int idx, stall_left, cyc, post;
        bit seen_done, v;
        tr.delete();
        base_v[d] = base; cnt_v[d] = CW'(n); start_v[d] = 1'b1; din_valid_v[d] = 1'b0;
        tick();
        start_v[d] = 1'b0;
        idx = 0; stall_left = stall_len; cyc = 0; post = 0; seen_done = 1'b0;
        while (post < 3 && cyc < 2000) begin
            tr.push_back(sample(d));
            if (done_v[d] === 1'b1) seen_done = 1'b1;
            if (seen_done) post++;
            if (cyc == restart_at) begin
                start_v[d] = 1'b1; base_v[d] = 20'h0ABCD; cnt_v[d] = 20'd7;
            end else begin
                start_v[d] = 1'b0;
            end
            if (idx < n) begin
                if (idx == stall_word && stall_left > 0 && rdy_v[d] === 1'b1) begin
                    v = 1'b0; stall_left--;
                end else if (rand_valid) begin
                    v = ($urandom_range(0, 2) != 0);
                end else begin
                    v = 1'b1;
                end
                din_valid_v[d] = v; din_v[d] = wdata[idx];
                if (v && rdy_v[d] === 1'b1) idx++;
            end else begin
                din_valid_v[d] = 1'b0;
            end
            tick();
            cyc++;
        end
        check("done_seen", seen_done, 1'b1);
        din_valid_v[d] = 1'b0;
    endtask

    // Rebuild the write list from WE_n low pulses and check each against the rules.
    task automatic analyze(input int d, input logic [AW-1:0] base, input int n,
                           input int exp_done, input int exp_rdy_run, input string tg);
        int s_c, p_c, h_c, sz, nw, len, run, max_run, done_cnt, done_idx;
        int bad_pulse, bad_stab, bad_data, bad_oe, bad_wait, bad_busy;
        logic [AW-1:0] ea;
        s_c = (d == 0) ? 1 : 2; p_c = (d == 0) ? 2 : 3; h_c = (d == 0) ? 1 : 2;
        sz = tr.size(); nw = 0; run = 0; max_run = 0; done_cnt = 0; done_idx = -1;
        bad_pulse = 0; bad_stab = 0; bad_data = 0; bad_oe = 0; bad_wait = 0; bad_busy = 0;
        for (int i = 0; i < sz; i++) begin
            if (tr[i].done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
        for (int i = 0; i < sz; i++) begin
            if (tr[i].oe_n !== 1'b1) bad_oe++;
            if (tr[i].rdy === 1'b1) begin
                run++;
                if (tr[i].ce_n !== 1'b1 || tr[i].io !== {DW{1'b1}}) bad_wait++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (done_idx >= 0 && tr[i].busy !== ((i < done_idx) ? 1'b1 : 1'b0)) bad_busy++;
            if (tr[i].we_n === 1'b0 && (i == 0 || tr[i-1].we_n === 1'b1)) begin
                len = 0;
                while (i + len < sz && tr[i+len].we_n === 1'b0) len++;
                if (len != p_c) bad_pulse++;
                for (int j = i - s_c; j < i + len + h_c; j++) begin
                    if (j < 0 || j >= sz) bad_stab++;
                    else if (tr[j].addr !== tr[i].addr || tr[j].io !== tr[i].io ||
                             tr[j].ce_n !== 1'b0 || tr[j].ub_n !== 1'b0 || tr[j].lb_n !== 1'b0)
                        bad_stab++;
                end
                ea = base + AW'(nw);
                if (nw >= n || tr[i].addr !== ea || tr[i].io !== wdata[nw]) bad_data++;
                nw++;
            end
        end
        check({tg, "_nwrites"}, nw, n);
        check({tg, "_pulse_len"}, bad_pulse, 0);
        check({tg, "_stable"}, bad_stab, 0);
        check({tg, "_addr_data"}, bad_data, 0);
        check({tg, "_oe_n"}, bad_oe, 0);
        check({tg, "_wait_bus"}, bad_wait, 0);
        check({tg, "_busy"}, bad_busy, 0);
        check({tg, "_done_cnt"}, done_cnt, 1);
        if (exp_done >= 0) check({tg, "_done_cyc"}, done_idx, exp_done);
        if (exp_rdy_run >= 0) check({tg, "_rdy_run"}, max_run, exp_rdy_run);
        if (sz > 0) check({tg, "_words_written"}, tr[sz-1].ww, n);
    endtask

    task automatic zero_len(input int d);
        int done_cnt, busy_cnt, we_cnt, ce_cnt, io_cnt;
        base_v[d] = 20'h12345; cnt_v[d] = 20'd0; start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        tr.delete();
        for (int i = 0; i < 5; i++) begin
            tr.push_back(sample(d));
            tick();
        end
        done_cnt = 0; busy_cnt = 0; we_cnt = 0; ce_cnt = 0; io_cnt = 0;
        foreach (tr[i]) begin
            if (tr[i].done === 1'b1) done_cnt++;
            if (tr[i].busy !== 1'b0) busy_cnt++;
            if (tr[i].we_n !== 1'b1) we_cnt++;
            if (tr[i].ce_n !== 1'b1) ce_cnt++;
            if (tr[i].io !== {DW{1'b1}}) io_cnt++;
        end
        check("zero_done_next", tr[0].done, 1'b1);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_busy", busy_cnt, 0);
        check("zero_we", we_cnt, 0);
        check("zero_ce", ce_cnt, 0);
        check("zero_io", io_cnt, 0);
    endtask

    initial begin
        int k, bad;
        logic [AW-1:0] rb;
        int rn;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; base_v[d] = '0; cnt_v[d] = '0; din_v[d] = '0; din_valid_v[d] = 1'b0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_ctl", {we_v[d], ce_v[d], oe_v[d], ub_v[d], lb_v[d]}, 5'b11111);
            check("rst_addr", addr_v[d], 20'h00000);
            check("rst_io", (d == 0) ? io0 : io1, {DW{1'b1}});
            check("rst_flags", {rdy_v[d], busy_v[d], done_v[d]}, 3'b000);
            check("rst_ww", ww_v[d], 20'd0);
        end
        rst = 1'b0;
        tick();

        // Basic burst, then the same with a 7-cycle stall before the second word.
        wdata = '{16'h1111, 16'h2222, 16'h3333};
        run_burst(0, 20'h00010, 3, -1, 0, 1'b0, -1);
        analyze(0, 20'h00010, 3, 15, 1, "basic");
        run_burst(0, 20'h00010, 3, 1, 7, 1'b0, -1);
        analyze(0, 20'h00010, 3, 22, 8, "stall");

        fill_random(4);
        run_burst(0, 20'hFFFFE, 4, -1, 0, 1'b0, -1);
        analyze(0, 20'hFFFFE, 4, 20, 1, "wrap");

        zero_len(0);
        zero_len(1);

        fill_random(5);
        run_burst(0, 20'h00100, 5, -1, 0, 1'b0, 6);
        analyze(0, 20'h00100, 5, 25, 1, "ignored_start");

        // Reset while WE_n is low.
        fill_random(5);
        base_v[0] = 20'h00200; cnt_v[0] = 20'd5; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; din_valid_v[0] = 1'b1; din_v[0] = wdata[0];
        k = 0;
        while (we_v[0] !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        check("rst_reach_we_low", we_v[0], 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_we_ce", {we_v[0], ce_v[0]}, 2'b11);
        check("midrst_io", io0, {DW{1'b1}});
        check("midrst_busy_done", {busy_v[0], done_v[0]}, 2'b00);
        rst = 1'b0; din_valid_v[0] = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || we_v[0] !== 1'b1) bad++;
        end
        check("midrst_quiet", bad, 0);

        // Stretched timing on the second instance.
        wdata = '{16'h1111, 16'h2222, 16'h3333};
        run_burst(1, 20'h00010, 3, -1, 0, 1'b0, -1);
        analyze(1, 20'h00010, 3, 24, 1, "t232_basic");
        fill_random(4);
        run_burst(1, 20'hFFFFE, 4, 2, 3, 1'b0, -1);
        analyze(1, 20'hFFFFE, 4, 35, 4, "t232_wrap");

        // Random commands with random valid gaps on both instances.
        for (int r = 0; r < 8; r++) begin
            rn = $urandom_range(1, 6);
            rb = (r % 3 == 0) ? AW'(20'hFFFFF - $urandom_range(0, 3)) : AW'($urandom);
            fill_random(rn);
            run_burst(r % 2, rb, rn, -1, 0, 1'b1, -1);
            analyze(r % 2, rb, rn, -1, -1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_writer.md
Name: sram_writer

Overview:
- Write-side controller for the board's external 1M x 16 asynchronous SRAM; counterpart of the existing read-only SRAM display path.
- Accepts a burst command (base address, word count) and a valid/ready data stream, then writes consecutive words.
- Each word uses a WE_n-controlled write cycle with programmable setup, pulse and hold lengths.
- Drives the shared IO bus only while a write cycle is in progress; high-Z at all other times.

Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- CNT_W, 20, width of word_count / words_written
- SETUP_CYC, 1, clocks with address and data valid and WE_n high before the WE_n pulse (min 1)
- PULSE_CYC, 2, clocks WE_n is held low (min 1)
- HOLD_CYC, 1, clocks address and data are held after WE_n rises (min 1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle command strobe, sampled only in IDLE
- base_addr  input  ADDR_W  first word address, captured on accepted start
- word_count  input  CNT_W  number of words to write, captured on accepted start
- din  input  DATA_W  write data
- din_valid  input  1  din holds a valid word
- din_ready  output  1  writer accepts din this cycle
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes
- words_written  output  CNT_W  words written in the current or last command
- CE_n, OE_n, WE_n, UB_n, LB_n  output  1 each  SRAM controls, active-low
- addr  output  ADDR_W  SRAM address
- IO  inout  DATA_W  SRAM data bus

Behaviour:
- All outputs are registered. IO is driven from a registered data value through a registered output enable.
- Reset values:
  - CE_n=1, OE_n=1, WE_n=1, UB_n=1, LB_n=1
  - addr=0, IO=high-Z
  - din_ready=0, busy=0, done=0, words_written=0
  - FSM in IDLE
- FSM states: IDLE, WAIT_DATA, SETUP, PULSE, HOLD, FINISH.
- IDLE:
  - On start=1 with word_count!=0: capture base_addr and word_count, clear words_written, set busy=1, go to WAIT_DATA.
  - On start=1 with word_count==0: go to FINISH with no SRAM activity.
- WAIT_DATA:
  - din_ready=1.
  - On din_valid=1, capture din, go to SETUP. din_ready drops on the next cycle.
  - Stalls indefinitely while din_valid=0; CE_n=1 and IO is high-Z during the stall.
- SETUP, SETUP_CYC clocks: CE_n=0, UB_n=LB_n=0, addr=current address, IO driven with the captured word, WE_n=1.
- PULSE, PULSE_CYC clocks: WE_n=0; addr and IO unchanged.
- HOLD, HOLD_CYC clocks: WE_n=1; addr and IO unchanged.
- On the last HOLD clock:
  - Increment the address modulo 2^ADDR_W (0xFFFFF wraps to 0x00000).
  - Increment words_written and decrement remaining.
  - If remaining becomes 0, go to FINISH; otherwise go to WAIT_DATA.
- FINISH, 1 clock:
  - done=1, busy drops to 0, CE_n=1, IO high-Z, then go to IDLE.
  - For word_count==0, busy stays 0 throughout and done is still pulsed one cycle after start.
- OE_n is held at 1 in every state; the controller never reads.
- Timing:
  - One word costs SETUP_CYC+PULSE_CYC+HOLD_CYC clocks after acceptance, plus 1 clock in WAIT_DATA when din_valid is already high.
  - Defaults: 5 clocks per word with continuous data.
- Address and data never change in the same clock that WE_n changes; both are stable across the entire low phase of WE_n.
- start while busy=1 is ignored; no queueing.
- Synchronous reset mid-operation:
  - On the first clk edge with rst=1: WE_n=1, CE_n=1, IO high-Z, busy=0, FSM to IDLE.
  - done is not pulsed; a partial word may be incomplete.
- words_written holds its final value after done until the next accepted start.

Test Plan:
- Basic burst: rst, then start with base_addr=0x00010, word_count=3, din_valid held high with din 0x1111/0x2222/0x3333.
  - Bus model records writes 0x00010=0x1111, 0x00011=0x2222, 0x00012=0x3333.
  - done pulses once, 15 clocks after WAIT_DATA entry (defaults); words_written=3.
- Backpressure: same command with din_valid low for 7 cycles before the second word.
  - din_ready stays high through the stall; CE_n=1 and IO=Z during the stall.
  - Write order and data unchanged.
- Address wrap: base_addr=0xFFFFE, word_count=4.
  - Writes land at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Zero length: start with word_count=0.
  - No WE_n low; done=1 exactly one cycle later; busy never asserts.
- Ignored start and mid-op reset:
  - Second start during a word_count=5 burst has no effect.
  - Asserting rst while WE_n=0 forces WE_n=1, CE_n=1, IO=Z on that edge; no done pulse.
- Timing check with SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2:
  - WE_n low exactly 3 clocks per word.
  - addr and IO stable from 2 clocks before WE_n falls until 2 clocks after it rises.
  - OE_n=1 throughout.
